// File: rtl/aeolus_mc_core.sv
// Aeolus multi-cycle accumulator core: FETCH/EXEC sequencer with a valid/ready output register.
// Optional build macro AEOLUS_PC_WRAP_HALT_EN: halt instead of wrapping the PC back to address 0.
module aeolus_mc_core #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_W-1:0]     imem_addr,
    input  logic [3:0]            imem_data,
    input  logic [2*DATA_W-1:0]   switches,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  carry,
    output logic                  halted
);

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        EXEC     = 2'd1,
        WAIT_OUT = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_LDB  = 4'h2;
    localparam logic [3:0] OP_LDO  = 4'h3;
    localparam logic [3:0] OP_CLR  = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_INV  = 4'hA;
    localparam logic [3:0] OP_LSH  = 4'hB;
    localparam logic [3:0] OP_RSH  = 4'hC;
    localparam logic [3:0] OP_SNZA = 4'hD;
    localparam logic [3:0] OP_SNZS = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    state_t              state, state_nxt, done_state;
    logic [ADDR_W-1:0]   pc, pc_nxt;
    logic [3:0]          ir, ir_nxt;
    logic [DATA_W-1:0]   a, a_nxt, b, b_nxt, acc, acc_nxt, o, o_nxt;
    logic                c, c_nxt, vld, vld_nxt;
    logic                ldo_ok, skip_cond;
`ifdef AEOLUS_PC_WRAP_HALT_EN
    logic                wrap, wrap_nxt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            pc    <= '0;
            ir    <= OP_NOP;
            a     <= '0;
            b     <= '0;
            acc   <= '0;
            o     <= '0;
            c     <= 1'b0;
            vld   <= 1'b0;
`ifdef AEOLUS_PC_WRAP_HALT_EN
            wrap  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
            a     <= a_nxt;
            b     <= b_nxt;
            acc   <= acc_nxt;
            o     <= o_nxt;
            c     <= c_nxt;
            vld   <= vld_nxt;
`ifdef AEOLUS_PC_WRAP_HALT_EN
            wrap  <= wrap_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        a_nxt     = a;
        b_nxt     = b;
        acc_nxt   = acc;
        o_nxt     = o;
        c_nxt     = c;
        // A pending O drains in every state, including HALT.
        vld_nxt   = vld & ~out_ready;
        ldo_ok    = ~vld | out_ready;
        skip_cond = 1'b0;
`ifdef AEOLUS_PC_WRAP_HALT_EN
        wrap_nxt   = wrap;
        done_state = wrap ? HALT : FETCH;
`else
        done_state = FETCH;
`endif

        case (state)
            FETCH: begin
                ir_nxt    = imem_data;
                pc_nxt    = pc + ADDR_W'(1);
                state_nxt = EXEC;
`ifdef AEOLUS_PC_WRAP_HALT_EN
                wrap_nxt  = (pc == '1);
`endif
            end
            EXEC: begin
                state_nxt = done_state;
                case (ir)
                    OP_NOP: ;
                    OP_LDA: a_nxt = switches[2*DATA_W-1:DATA_W];
                    OP_LDB: b_nxt = switches[DATA_W-1:0];
                    OP_LDO: begin
                        if (ldo_ok) begin
                            o_nxt   = acc;
                            vld_nxt = 1'b1;
                        end else begin
                            state_nxt = WAIT_OUT;
                        end
                    end
                    OP_CLR: begin
                        acc_nxt = '0;
                        c_nxt   = 1'b0;
                    end
                    OP_ADD: {c_nxt, acc_nxt} = {1'b0, a} + {1'b0, b};
                    OP_SUB: begin
                        acc_nxt = a - b;
                        c_nxt   = (a < b);
                    end
                    OP_AND: acc_nxt = a & b;
                    OP_OR:  acc_nxt = a | b;
                    OP_XOR: acc_nxt = a ^ b;
                    OP_INV: acc_nxt = ~a;
                    OP_LSH: begin
                        acc_nxt = acc << 1;
                        c_nxt   = acc[DATA_W-1];
                    end
                    OP_RSH: begin
                        acc_nxt = acc >> 1;
                        c_nxt   = acc[0];
                    end
                    OP_SNZA: skip_cond = (a != '0);
                    OP_SNZS: skip_cond = (acc != '0);
                    OP_HLT:  state_nxt = HALT;
                    default: ;
                endcase
                if (skip_cond) begin
                    pc_nxt = pc + ADDR_W'(1);
`ifdef AEOLUS_PC_WRAP_HALT_EN
                    if (pc == '1)
                        state_nxt = HALT;
`endif
                end
            end
            WAIT_OUT: begin
                if (ldo_ok) begin
                    o_nxt     = acc;
                    vld_nxt   = 1'b1;
                    state_nxt = done_state;
                end
            end
            HALT: ;
            default: state_nxt = FETCH;
        endcase
    end

    assign imem_addr = pc;
    assign out_data  = o;
    assign out_valid = vld;
    assign carry     = c;
    assign halted    = (state == HALT);

endmodule

// File: tb/tb_aeolus_mc_core.sv
// Directed bench for aeolus_mc_core: table of small programs plus hand-timed handshake/wrap/reset sequences.
module tb_aeolus_mc_core;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] imem_addr;
    logic [3:0] imem_data;
    logic [7:0] switches = 8'h00;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       carry;
    logic       halted;

    logic [3:0] rom [16];
    int         n_checks = 0;
    int         n_fail = 0;
    int         xfer_cnt = 0;
    logic [3:0] first_o = 4'h0;
    logic [3:0] last_o = 4'h0;

    always #5 clk = ~clk;
    assign imem_data = rom[imem_addr];

    aeolus_mc_core #(.DATA_W(4), .ADDR_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .switches  (switches),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .carry     (carry),
        .halted    (halted)
    );

    // Record every accepted O value.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (xfer_cnt == 0) first_o = out_data;
            last_o = out_data;
            xfer_cnt++;
        end
    end

    typedef struct {
        string       name;
        logic [63:0] prog;
        logic [7:0]  sw;
        logic [3:0]  exp_o;
        logic        exp_c;
        logic [3:0]  exp_addr;
        int          exp_xfers;
        logic [3:0]  exp_first;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_prog(input logic [63:0] prog);
        for (int i = 0; i < 16; i++) rom[i] = prog[i*4 +: 4];
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        xfer_cnt = 0;
        first_o  = 4'h0;
        last_o   = 4'h0;
        reset    = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{"add_93",   64'h0000_0000_000F_3521, 8'h93, 4'hC, 1'b0, 4'h5, 1, 4'hC};
        vecs[1]  = '{"add_sub",  64'h0000_0000_0F36_3521, 8'h9A, 4'hF, 1'b1, 4'h7, 2, 4'h3};
        vecs[2]  = '{"skips",    64'h0000_0000_F3FD_13E4, 8'h10, 4'h0, 1'b0, 4'h8, 2, 4'h0};
        vecs[3]  = '{"and_keepc",64'h0000_0000_00F3_7521, 8'h9A, 4'h8, 1'b1, 4'h6, 1, 4'h8};
        vecs[4]  = '{"or",       64'h0000_0000_000F_3821, 8'hC6, 4'hE, 1'b0, 4'h5, 1, 4'hE};
        vecs[5]  = '{"xor",      64'h0000_0000_000F_3921, 8'hC6, 4'hA, 1'b0, 4'h5, 1, 4'hA};
        vecs[6]  = '{"inv",      64'h0000_0000_0000_F3A1, 8'hC6, 4'h3, 1'b0, 4'h4, 1, 4'h3};
        vecs[7]  = '{"lsh",      64'h0000_0000_00F3_B521, 8'h95, 4'hC, 1'b1, 4'h6, 1, 4'hC};
        vecs[8]  = '{"rsh",      64'h0000_0000_00F3_C521, 8'h54, 4'h4, 1'b1, 4'h6, 1, 4'h4};
        vecs[9]  = '{"clr",      64'h0000_0000_00F3_4521, 8'h9A, 4'h0, 1'b0, 4'h6, 1, 4'h0};
        vecs[10] = '{"sub_nb",   64'h0000_0000_000F_3621, 8'h73, 4'h4, 1'b0, 4'h5, 1, 4'h4};

        // Reset state
        load_prog(64'h0);
        reset = 1'b0;
        #1;
        check("rst_addr", imem_addr, 0);
        check("rst_out", out_data, 0);
        check("rst_valid", out_valid, 0);
        check("rst_carry", carry, 0);
        check("rst_halted", halted, 0);

        // Table-driven programs with out_ready held high
        foreach (vecs[k]) begin
            load_prog(vecs[k].prog);
            switches  = vecs[k].sw;
            out_ready = 1'b1;
            do_reset();
            tick(40);
            check({vecs[k].name, "_out"}, out_data, vecs[k].exp_o);
            check({vecs[k].name, "_carry"}, carry, vecs[k].exp_c);
            check({vecs[k].name, "_halted"}, halted, 1);
            check({vecs[k].name, "_addr"}, imem_addr, vecs[k].exp_addr);
            check({vecs[k].name, "_xfers"}, xfer_cnt, vecs[k].exp_xfers);
            check({vecs[k].name, "_first"}, first_o, vecs[k].exp_first);
            check({vecs[k].name, "_valid"}, out_valid, 0);
        end

        // Cycle timing of the first program: valid pulse after LDO EXEC, halt after 10 cycles
        load_prog(vecs[0].prog);
        switches  = 8'h93;
        out_ready = 1'b1;
        do_reset();
        tick(7);
        check("t1_valid_c7", out_valid, 0);
        tick(1);
        check("t1_valid_c8", out_valid, 1);
        check("t1_data_c8", out_data, 4'hC);
        tick(1);
        check("t1_valid_c9", out_valid, 0);
        check("t1_halted_c9", halted, 0);
        tick(1);
        check("t1_halted_c10", halted, 1);

        // Back-pressure: second LDO stalls, then transfer and reload in one cycle
        load_prog(64'h0000_0000_00F3_5213);
        switches  = 8'h12;
        out_ready = 1'b0;
        do_reset();
        tick(2);
        check("bp_first_load", out_valid, 1);
        tick(10);
        check("bp_stall_valid", out_valid, 1);
        check("bp_stall_data", out_data, 0);
        check("bp_stall_pc", imem_addr, 5);
        tick(3);
        check("bp_pc_frozen", imem_addr, 5);
        check("bp_data_stable", out_data, 0);
        out_ready = 1'b1;
        tick(1);
        check("bp_reload_valid", out_valid, 1);
        check("bp_reload_data", out_data, 4'h3);
        tick(1);
        check("bp_drain_valid", out_valid, 0);
        check("bp_resume_pc", imem_addr, 6);
        tick(2);
        check("bp_halted", halted, 1);
        check("bp_xfers", xfer_cnt, 2);
        check("bp_first", first_o, 0);
        check("bp_last", last_o, 4'h3);

        // All-NOP program: PC wrap
        load_prog(64'h0);
        out_ready = 1'b1;
        do_reset();
        tick(32);
        check("wrap_addr", imem_addr, 0);
`ifdef AEOLUS_PC_WRAP_HALT_EN
        check("wrap_halted", halted, 1);
        tick(2);
        check("wrap_stay_addr", imem_addr, 0);
        check("wrap_stay_halted", halted, 1);
`else
        check("wrap_halted", halted, 0);
        tick(2);
        check("wrap_run_addr", imem_addr, 1);
        check("wrap_run_halted", halted, 0);
`endif

        // Asynchronous reset during EXEC of ADD
        load_prog(64'h0000_0000_F521_3521);
        switches  = 8'h9A;
        out_ready = 1'b0;
        do_reset();
        tick(13);
        check("ar_pre_data", out_data, 4'h3);
        check("ar_pre_valid", out_valid, 1);
        check("ar_pre_carry", carry, 1);
        check("ar_pre_addr", imem_addr, 7);
        #2;
        reset = 1'b0;
        #1;
        check("ar_data", out_data, 0);
        check("ar_valid", out_valid, 0);
        check("ar_carry", carry, 0);
        check("ar_addr", imem_addr, 0);
        check("ar_halted", halted, 0);
        tick(1);
        reset = 1'b1;
        tick(1);
        check("ar_refetch", imem_addr, 1);
        tick(7);
        check("ar_rerun_data", out_data, 4'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
